// File: rtl/i2c_master_arbiter_if.sv
// Bundle of requester-side and I2C-master-side signals shared by the arbiter.
// The arbiter connects through "master"; the requesters and the I2C master connect through "slave".
interface i2c_master_arbiter_if #(
   parameter int N_REQ = 4
);
   // Requester side
   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   req_rw;
   logic [7*N_REQ-1:0] req_addr;
   logic [8*N_REQ-1:0] req_wdata;
   logic [N_REQ-1:0]   req_next_byte;
   logic [N_REQ-1:0]   grant;
   logic [N_REQ-1:0]   rsp_valid;
   logic [7:0]         rsp_rdata;
   logic               rsp_ack_error;
   logic               rsp_timeout;
   logic               busy;

   // I2C master side
   logic               m_start_txn;
   logic               m_rw;
   logic [6:0]         m_sub_addr;
   logic [7:0]         m_data_in;
   logic               m_next_byte;
   logic               m_done;
   logic               m_ack_error;
   logic [7:0]         m_data_out;

   modport master (
      input  req, req_rw, req_addr, req_wdata, req_next_byte,
      input  m_done, m_ack_error, m_data_out,
      output grant, rsp_valid, rsp_rdata, rsp_ack_error, rsp_timeout, busy,
      output m_start_txn, m_rw, m_sub_addr, m_data_in, m_next_byte
   );

   modport slave (
      output req, req_rw, req_addr, req_wdata, req_next_byte,
      output m_done, m_ack_error, m_data_out,
      input  grant, rsp_valid, rsp_rdata, rsp_ack_error, rsp_timeout, busy,
      input  m_start_txn, m_rw, m_sub_addr, m_data_in, m_next_byte
   );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master among N_REQ requesters,
// with a done timeout and an enforced idle gap between transactions.
module i2c_master_arbiter #(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int GAP_CYCLES     = 4
) (
   input logic                  clk_400,
   input logic                  rst,
   i2c_master_arbiter_if.master arb_if
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_RESP,
      ST_GAP
   } state_e;

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               m_rw_q, m_rw_d;
   logic [6:0]         m_sub_addr_q, m_sub_addr_d;
   logic [7:0]         m_data_in_q, m_data_in_d;
   logic               m_next_byte_q, m_next_byte_d;
   logic [7:0]         rsp_rdata_q, rsp_rdata_d;
   logic               rsp_ack_error_q, rsp_ack_error_d;
   logic               rsp_timeout_q, rsp_timeout_d;
   logic [TMO_W-1:0]   timer_q, timer_d;
   logic [GAP_W-1:0]   gap_q, gap_d;

   logic               req_any;
   logic [PTR_W-1:0]   pick_idx;
   logic [TMO_W-1:0]   timer_inc;
   logic               tmo_hit;
   logic               gap_done;

   // Per-requester fields unpacked so they can be selected by a narrow index.
   logic [6:0]         addr_arr  [N_REQ];
   logic [7:0]         wdata_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = arb_if.req_addr[7*g +: 7];
      assign wdata_arr[g] = arb_if.req_wdata[8*g +: 8];
   end

   // First set request at or above rr_ptr, wrapping modulo N_REQ.
   always_comb begin : rr_pick
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] cand;
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      req_any  = 1'b0;
      pick_idx = '0;
      sum      = '0;
      cand     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(N_REQ)) begin
            sum = sum - (PTR_W+1)'(N_REQ);
         end
         cand = sum[PTR_W-1:0];
         if (!req_any && arb_if.req[cand]) begin
            req_any  = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign timer_inc = timer_q + TMO_W'(1);
   assign tmo_hit   = (timer_inc == TMO_W'(TIMEOUT_CYCLES - 1));
   assign gap_done  = !arb_if.m_done && (gap_q == GAP_W'(GAP_CYCLES - 1));

   // State register
   always_ff @(posedge clk_400) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (req_any) state_d = ST_START;
         ST_START: state_d = ST_WAIT;
         ST_WAIT:  if (arb_if.m_done || tmo_hit) state_d = ST_RESP;
         ST_RESP:  state_d = ST_GAP;
         ST_GAP:   if (gap_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      arb_if.m_start_txn = (state_q == ST_START);
      arb_if.rsp_valid   = (state_q == ST_RESP) ? grant_q : '0;
      arb_if.busy        = (state_q != ST_IDLE);
   end

   assign arb_if.grant         = grant_q;
   assign arb_if.m_rw          = m_rw_q;
   assign arb_if.m_sub_addr    = m_sub_addr_q;
   assign arb_if.m_data_in     = m_data_in_q;
   assign arb_if.m_next_byte   = m_next_byte_q;
   assign arb_if.rsp_rdata     = rsp_rdata_q;
   assign arb_if.rsp_ack_error = rsp_ack_error_q;
   assign arb_if.rsp_timeout   = rsp_timeout_q;

   // Datapath next values
   always_comb begin
      grant_d         = grant_q;
      owner_d         = owner_q;
      rr_ptr_d        = rr_ptr_q;
      m_rw_d          = m_rw_q;
      m_sub_addr_d    = m_sub_addr_q;
      m_data_in_d     = m_data_in_q;
      m_next_byte_d   = m_next_byte_q;
      rsp_rdata_d     = rsp_rdata_q;
      rsp_ack_error_d = rsp_ack_error_q;
      rsp_timeout_d   = rsp_timeout_q;
      timer_d         = timer_q;
      gap_d           = gap_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               owner_d           = pick_idx;
               m_rw_d            = arb_if.req_rw[pick_idx];
               m_sub_addr_d      = addr_arr[pick_idx];
               m_data_in_d       = wdata_arr[pick_idx];
               m_next_byte_d     = arb_if.req_next_byte[pick_idx];
            end
         end
         ST_START: begin
            timer_d = '0;
         end
         ST_WAIT: begin
            timer_d = timer_inc;
            // A done arriving in the same cycle as the timeout wins.
            if (arb_if.m_done) begin
               rsp_rdata_d     = arb_if.m_data_out;
               rsp_ack_error_d = arb_if.m_ack_error;
               rsp_timeout_d   = 1'b0;
            end else if (tmo_hit) begin
               rsp_rdata_d     = '0;
               rsp_ack_error_d = 1'b0;
               rsp_timeout_d   = 1'b1;
            end
         end
         ST_RESP: begin
            rr_ptr_d = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
            gap_d    = '0;
         end
         ST_GAP: begin
            // A master holding done as a level keeps the gap from starting to count.
            gap_d = arb_if.m_done ? '0 : gap_q + GAP_W'(1);
            if (gap_done) begin
               grant_d = '0;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk_400) begin
      if (rst) begin
         grant_q         <= '0;
         owner_q         <= '0;
         rr_ptr_q        <= '0;
         m_rw_q          <= 1'b0;
         m_sub_addr_q    <= '0;
         m_data_in_q     <= '0;
         m_next_byte_q   <= 1'b0;
         rsp_rdata_q     <= '0;
         rsp_ack_error_q <= 1'b0;
         rsp_timeout_q   <= 1'b0;
         timer_q         <= '0;
         gap_q           <= '0;
      end else begin
         grant_q         <= grant_d;
         owner_q         <= owner_d;
         rr_ptr_q        <= rr_ptr_d;
         m_rw_q          <= m_rw_d;
         m_sub_addr_q    <= m_sub_addr_d;
         m_data_in_q     <= m_data_in_d;
         m_next_byte_q   <= m_next_byte_d;
         rsp_rdata_q     <= rsp_rdata_d;
         rsp_ack_error_q <= rsp_ack_error_d;
         rsp_timeout_q   <= rsp_timeout_d;
         timer_q         <= timer_d;
         gap_q           <= gap_d;
      end
   end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: directed requests with hand-computed
// expectations, a behavioural I2C master/subordinate, and a monitor that pops and compares.
module tb_i2c_master_arbiter;

   localparam int N   = 4;
   localparam int TMO = 16;
   localparam int GAP = 4;
   localparam int LAT = 5;

   typedef struct {
      int         idx;
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
      logic       nb;
   } start_t;

   typedef struct {
      int         idx;
      logic [7:0] rdata;
      logic       ack;
      logic       tmo;
      int         lat;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   i2c_master_arbiter_if #(.N_REQ(N)) bus ();

   i2c_master_arbiter #(
      .N_REQ(N),
      .TIMEOUT_CYCLES(TMO),
      .GAP_CYCLES(GAP)
   ) dut (
      .clk_400(clk),
      .rst(rst),
      .arb_if(bus)
   );

   always #5 clk = ~clk;

   int     cyc = 0;
   int     n_tests = 0;
   int     n_fail = 0;
   int     rsp_cnt = 0;
   int     start_cnt = 0;
   int     last_start_cyc = 0;
   int     last_done_cyc = 0;
   int     start_after_done = 0;
   start_t exp_start[$];
   rsp_t   exp_rsp[$];

   // Behavioural master + subordinate at address 0x01
   logic       hang = 1'b0;
   int         done_hold = 1;
   logic [7:0] mem = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input int idx, input logic rw, input logic [6:0] addr,
                             input logic [7:0] wdata, input logic nb);
      bus.req_rw[idx]           = rw;
      bus.req_addr[idx*7 +: 7]  = addr;
      bus.req_wdata[idx*8 +: 8] = wdata;
      bus.req_next_byte[idx]    = nb;
   endtask

   task automatic expect_txn(input int idx, input logic rw, input logic [6:0] addr,
                             input logic [7:0] wdata, input logic nb, input logic [7:0] rdata,
                             input logic ack, input logic tmo, input int lat);
      start_t s;
      rsp_t   r;
      s.idx = idx; s.rw = rw; s.addr = addr; s.wdata = wdata; s.nb = nb;
      r.idx = idx; r.rdata = rdata; r.ack = ack; r.tmo = tmo; r.lat = lat;
      exp_start.push_back(s);
      exp_rsp.push_back(r);
   endtask

   task automatic wait_rsp(input int target);
      logic ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (rsp_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
      check($sformatf("rsp_arrived_%0d", target), 32'(ok), 32'd1);
   endtask

   task automatic wait_start(input int target);
      logic ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (start_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
      check($sformatf("start_arrived_%0d", target), 32'(ok), 32'd1);
   endtask

   task automatic wait_idle(input string name);
      logic ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (!bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_idle"}, 32'(ok), 32'd1);
   endtask

   task automatic check_zero(input string p);
      check({p, "_grant"},     32'(bus.grant),         32'd0);
      check({p, "_rsp_valid"}, 32'(bus.rsp_valid),     32'd0);
      check({p, "_rsp_rdata"}, 32'(bus.rsp_rdata),     32'd0);
      check({p, "_rsp_ack"},   32'(bus.rsp_ack_error), 32'd0);
      check({p, "_rsp_tmo"},   32'(bus.rsp_timeout),   32'd0);
      check({p, "_busy"},      32'(bus.busy),          32'd0);
      check({p, "_m_start"},   32'(bus.m_start_txn),   32'd0);
      check({p, "_m_rw"},      32'(bus.m_rw),          32'd0);
      check({p, "_m_addr"},    32'(bus.m_sub_addr),    32'd0);
      check({p, "_m_data"},    32'(bus.m_data_in),     32'd0);
      check({p, "_m_nb"},      32'(bus.m_next_byte),   32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   // Master model: answers each start pulse LAT cycles later unless hung.
   initial begin
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
      forever begin
         @(negedge clk);
         if (bus.m_start_txn && !hang) begin
            rw    = bus.m_rw;
            addr  = bus.m_sub_addr;
            wdata = bus.m_data_in;
            repeat (LAT) @(posedge clk);
            #1;
            if (addr == 7'h01) begin
               bus.m_ack_error = 1'b0;
               if (rw) begin
                  bus.m_data_out = mem;
               end else begin
                  mem            = wdata;
                  bus.m_data_out = 8'h00;
               end
            end else begin
               bus.m_ack_error = 1'b1;
               bus.m_data_out  = 8'h00;
            end
            bus.m_done = 1'b1;
            repeat (done_hold) @(posedge clk);
            #1;
            bus.m_done = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT starts or completes a transaction.
   always @(negedge clk) begin
      if (bus.m_done) last_done_cyc = cyc;
      if (bus.m_start_txn) begin
         start_cnt++;
         start_after_done = cyc - last_done_cyc;
         last_start_cyc   = cyc;
         check("start_grant_onehot", 32'($onehot0(bus.grant)), 32'd1);
         if (exp_start.size() == 0) begin
            check("unexpected_start", 32'd1, 32'd0);
         end else begin
            start_t s;
            s = exp_start.pop_front();
            check("start_grant", 32'(bus.grant),       32'd1 << s.idx);
            check("start_rw",    32'(bus.m_rw),        32'(s.rw));
            check("start_addr",  32'(bus.m_sub_addr),  32'(s.addr));
            check("start_data",  32'(bus.m_data_in),   32'(s.wdata));
            check("start_nb",    32'(bus.m_next_byte), 32'(s.nb));
         end
      end
      if (|bus.rsp_valid) begin
         rsp_cnt++;
         if (exp_rsp.size() == 0) begin
            check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
         end else begin
            rsp_t r;
            r = exp_rsp.pop_front();
            check("rsp_valid", 32'(bus.rsp_valid),     32'd1 << r.idx);
            check("rsp_grant", 32'(bus.grant),         32'd1 << r.idx);
            check("rsp_rdata", 32'(bus.rsp_rdata),     32'(r.rdata));
            check("rsp_ack",   32'(bus.rsp_ack_error), 32'(r.ack));
            check("rsp_tmo",   32'(bus.rsp_timeout),   32'(r.tmo));
            if (r.lat != 0) begin
               check("rsp_latency", 32'(cyc - last_start_cyc), 32'(r.lat));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.req           = '0;
      bus.req_rw        = '0;
      bus.req_addr      = '0;
      bus.req_wdata     = '0;
      bus.req_next_byte = '0;
      bus.m_done        = 1'b0;
      bus.m_ack_error   = 1'b0;
      bus.m_data_out    = 8'h00;

      // Reset state
      repeat (3) tick();
      check_zero("reset");
      rst = 1'b0;
      tick();

      // Single writer
      set_fields(1, 1'b0, 7'h01, 8'hAB, 1'b0);
      expect_txn(1, 1'b0, 7'h01, 8'hAB, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      bus.req[1] = 1'b1;
      wait_rsp(1);
      bus.req[1] = 1'b0;
      wait_idle("t1");
      check("t1_sub_mem", 32'(mem), 32'hAB);

      // Single reader
      mem = 8'hC3;
      set_fields(2, 1'b1, 7'h01, 8'h00, 1'b1);
      expect_txn(2, 1'b1, 7'h01, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 0);
      bus.req[2] = 1'b1;
      wait_rsp(2);
      bus.req[2] = 1'b0;
      wait_idle("t2");

      // Round-robin from rr_ptr = 0: order 0,1,2,3,0
      do_reset();
      for (int i = 0; i < N; i++) begin
         set_fields(i, 1'b0, 7'h01, 8'h10 + 8'(i), i[0]);
      end
      for (int i = 0; i < N; i++) begin
         expect_txn(i, 1'b0, 7'h01, 8'h10 + 8'(i), i[0], 8'h00, 1'b0, 1'b0, 0);
      end
      expect_txn(0, 1'b0, 7'h01, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      bus.req = 4'b1111;
      wait_rsp(7);
      bus.req = '0;
      wait_idle("t3");

      // Wrong address: NACK
      set_fields(0, 1'b0, 7'h55, 8'h66, 1'b0);
      expect_txn(0, 1'b0, 7'h55, 8'h66, 1'b0, 8'h00, 1'b1, 1'b0, 0);
      bus.req[0] = 1'b1;
      wait_rsp(8);
      bus.req[0] = 1'b0;
      wait_idle("t4");

      // Hung master: timeout response 16 cycles after START, stale read data discarded
      hang           = 1'b1;
      bus.m_data_out = 8'h5A;
      set_fields(3, 1'b1, 7'h01, 8'h00, 1'b0);
      expect_txn(3, 1'b1, 7'h01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, TMO);
      bus.req[3] = 1'b1;
      wait_rsp(9);
      bus.req[3] = 1'b0;
      wait_idle("t5a");

      // Reset during WAIT aborts with no response
      set_fields(0, 1'b0, 7'h01, 8'h77, 1'b1);
      exp_start.push_back('{idx: 0, rw: 1'b0, addr: 7'h01, wdata: 8'h77, nb: 1'b1});
      bus.req[0] = 1'b1;
      wait_start(start_cnt + 1);
      repeat (3) tick();
      rst        = 1'b1;
      bus.req[0] = 1'b0;
      tick();
      check_zero("abort");
      rst = 1'b0;
      repeat (30) tick();
      check("abort_no_rsp", 32'(rsp_cnt), 32'd9);
      hang = 1'b0;

      // Done held high after RESP: next start GAP+2 cycles after last high cycle
      done_hold = 11;
      set_fields(1, 1'b0, 7'h01, 8'h99, 1'b0);
      expect_txn(1, 1'b0, 7'h01, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      expect_txn(1, 1'b0, 7'h01, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      bus.req[1] = 1'b1;
      wait_rsp(10);
      done_hold = 1;
      wait_rsp(11);
      bus.req[1] = 1'b0;
      check("t6_done_to_start", 32'(start_after_done), 32'(GAP + 2));
      wait_idle("t6");

      check("leftover_rsp",   32'(exp_rsp.size()),   32'd0);
      check("leftover_start", 32'(exp_start.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
